// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the cnn_core inference block: FSM state encoding,
// default geometry (image, kernel, convolution and pooled sizes, flattened
// vector length), word widths and the word typedefs used by the datapath.
// No ports; imported by cnn_core and cnn_conv3x3.
// ---------------------------------------------------------------------------
package cnn_pkg;

   localparam int IMG_W    = 12;
   localparam int IMG_H    = 12;
   localparam int N_FEAT   = 2;
   localparam int K_SIZE   = 3;
   localparam int CONV_W   = IMG_W - K_SIZE + 1;
   localparam int CONV_H   = IMG_H - K_SIZE + 1;
   localparam int POOL_W   = CONV_W / 2;
   localparam int POOL_H   = CONV_H / 2;
   localparam int FLAT_LEN = N_FEAT * POOL_W * POOL_H;

   localparam int PIX_DW   = 2;
   localparam int CONV_DW  = 8;
   localparam int FC_DW    = 8;
   localparam int OUT_DW   = 32;

   typedef enum logic [2:0] {
      IDLE           = 3'd0,
      CONVOLUTION    = 3'd1,
      POOLING        = 3'd2,
      FLATTENING     = 3'd3,
      FULLYCONNECTED = 3'd4,
      OUTPUT         = 3'd5
   } state_t;

   typedef logic signed [PIX_DW-1:0]  pixel_t;
   typedef logic signed [CONV_DW-1:0] conv_t;
   typedef logic signed [FC_DW-1:0]   fc_t;

   // Signed maximum of two convolution words.
   function automatic conv_t max_s(input conv_t a, input conv_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cnn_conv3x3.sv
// ---------------------------------------------------------------------------
// cnn_conv3x3
// Combinational 3x3 dot product of a pixel window with one kernel.
// Ports:
//   i_window : 9 packed 2-bit signed pixels, tap k = r*3+c, tap 0 in MSBs
//   i_kernel : 9 packed 2-bit signed weights, same tap ordering
//   o_sum    : signed sum of the 9 products, sign-extended to CONV_DW bits
// ---------------------------------------------------------------------------
module cnn_conv3x3
   import cnn_pkg::*;
(
   input  logic [PIX_DW*K_SIZE*K_SIZE-1:0] i_window,
   input  logic [PIX_DW*K_SIZE*K_SIZE-1:0] i_kernel,
   output logic signed [CONV_DW-1:0]       o_sum
);

   localparam int TAPS = K_SIZE * K_SIZE;

   conv_t w_sum;

   // Each 2-bit operand is sign-extended before the multiply so the
   // product is formed at full word width.
   always_comb begin
      w_sum = '0;
      for (int k = 0; k < TAPS; k++) begin
         w_sum = w_sum
               + conv_t'(pixel_t'(i_window[PIX_DW*(TAPS-1-k) +: PIX_DW]))
               * conv_t'(pixel_t'(i_kernel[PIX_DW*(TAPS-1-k) +: PIX_DW]));
      end
   end

   assign o_sum = w_sum;

endmodule

// File: rtl/cnn_core.sv
// ---------------------------------------------------------------------------
// cnn_core
// Fixed-function CNN: 2-bit image -> NUM_FEATURES 3x3 valid convolutions ->
// 2x2 max pool -> flatten -> fully-connected reduction to one 32-bit score.
// Ports:
//   clk                          : clock, rising edge
//   rst_cnn                      : sync reset of FSM, counters, datapath, output
//   rst_feature_weights          : sync clear of the kernel memory
//   rst_fullyconnected_weights   : sync clear of the FC weight memory
//   image_input                  : packed image, pixel (0,0) in the MSBs
//   feature_weights_input        : packed kernel, tap 0 in the MSBs
//   feature_writeAddr            : kernel slot to write
//   feature_WrEn                 : active-low kernel write (IDLE only)
//   fullyconnected_weights_input : packed FC weights, index 0 in the MSBs
//   fullyconnected_WrEn          : active-low FC weight write (IDLE only)
//   convolution_enable           : active-low start (IDLE only)
//   cnn_output                   : signed score, held until next result/reset
// ---------------------------------------------------------------------------
module cnn_core
   import cnn_pkg::*;
#(
   parameter int IMAGE_WIDTH               = IMG_W,
   parameter int IMAGE_HEIGHT              = IMG_H,
   parameter int NUM_FEATURES              = N_FEAT,
   parameter int KERNEL_SIZE               = K_SIZE,
   parameter int CONVOLUTION_WIDTH         = CONV_W,
   parameter int CONVOLUTION_HEIGHT        = CONV_H,
   parameter int POOLED_WIDTH              = POOL_W,
   parameter int POOLED_HEIGHT             = POOL_H,
   parameter int FLATTENED_LENGTH          = FLAT_LEN,
   parameter int CONVOLUTION_DATA_WIDTH    = CONV_DW,
   parameter int FULLYCONNECTED_DATA_WIDTH = FC_DW,
   parameter int OUTPUT_DATA_WIDTH         = OUT_DW
)(
   input  logic                                                  clk,
   input  logic                                                  rst_cnn,
   input  logic                                                  rst_feature_weights,
   input  logic                                                  rst_fullyconnected_weights,
   input  logic [2*IMAGE_HEIGHT*IMAGE_WIDTH-1:0]                 image_input,
   input  logic [2*KERNEL_SIZE*KERNEL_SIZE-1:0]                  feature_weights_input,
   input  logic [$clog2(NUM_FEATURES):0]                         feature_writeAddr,
   input  logic                                                  feature_WrEn,
   input  logic [FULLYCONNECTED_DATA_WIDTH*FLATTENED_LENGTH-1:0] fullyconnected_weights_input,
   input  logic                                                  fullyconnected_WrEn,
   input  logic                                                  convolution_enable,
   output logic [OUTPUT_DATA_WIDTH-1:0]                          cnn_output
);

   localparam int IMG_BITS = 2 * IMAGE_HEIGHT * IMAGE_WIDTH;
   localparam int KER_BITS = 2 * KERNEL_SIZE * KERNEL_SIZE;
   localparam int FCW_BITS = FULLYCONNECTED_DATA_WIDTH * FLATTENED_LENGTH;
   localparam int RC_W     = $clog2(IMAGE_WIDTH > IMAGE_HEIGHT ? IMAGE_WIDTH : IMAGE_HEIGHT);
   localparam int PRC_W    = $clog2(POOLED_WIDTH > POOLED_HEIGHT ? POOLED_WIDTH : POOLED_HEIGHT);
   localparam int FCI_W    = $clog2(FLATTENED_LENGTH);

   // ---------------- state and storage ----------------
   state_t state;
   state_t w_next_state;

   logic [IMG_BITS-1:0]                      r_image;
   logic [KER_BITS-1:0]                      r_kernel [NUM_FEATURES];
   logic signed [FULLYCONNECTED_DATA_WIDTH-1:0] r_fc_w [FLATTENED_LENGTH];

   logic signed [CONVOLUTION_DATA_WIDTH-1:0] r_conv [NUM_FEATURES][CONVOLUTION_HEIGHT][CONVOLUTION_WIDTH];
   logic signed [CONVOLUTION_DATA_WIDTH-1:0] r_pool [NUM_FEATURES][POOLED_HEIGHT][POOLED_WIDTH];
   logic signed [CONVOLUTION_DATA_WIDTH-1:0] r_flat [FLATTENED_LENGTH];

   logic [RC_W-1:0]  r_row, r_col;     // convolution position
   logic [PRC_W-1:0] r_prow, r_pcol;   // pooled position
   logic [FCI_W-1:0] r_fc_idx;         // FC MAC index
   logic signed [OUTPUT_DATA_WIDTH-1:0] r_acc;

   // ---------------- FSM control decode ----------------
   logic w_start, w_conv_en, w_pool_en, w_flat_en, w_fc_en, w_out_en;
   logic w_col_last, w_conv_last, w_pcol_last, w_pool_last, w_fc_last;

   assign w_col_last  = (int'(r_col) == CONVOLUTION_WIDTH - 1);
   assign w_conv_last = w_col_last && (int'(r_row) == CONVOLUTION_HEIGHT - 1);
   assign w_pcol_last = (int'(r_pcol) == POOLED_WIDTH - 1);
   assign w_pool_last = w_pcol_last && (int'(r_prow) == POOLED_HEIGHT - 1);
   assign w_fc_last   = (int'(r_fc_idx) == FLATTENED_LENGTH - 1);

   // ---------------- image window and convolution ----------------
   logic [1:0]          w_pix [IMAGE_HEIGHT][IMAGE_WIDTH];
   logic [KER_BITS-1:0] w_window;
   logic signed [CONVOLUTION_DATA_WIDTH-1:0] w_conv_sum [NUM_FEATURES];
   logic signed [CONVOLUTION_DATA_WIDTH-1:0] w_pool_max [NUM_FEATURES];

   for (genvar r = 0; r < IMAGE_HEIGHT; r++) begin : g_pix_r
      for (genvar c = 0; c < IMAGE_WIDTH; c++) begin : g_pix_c
         assign w_pix[r][c] = r_image[IMG_BITS-1-2*(r*IMAGE_WIDTH+c) -: 2];
      end
   end

   // Window anchored at the current (row, col); tap ordering matches the kernel.
   for (genvar kr = 0; kr < KERNEL_SIZE; kr++) begin : g_win_r
      for (genvar kc = 0; kc < KERNEL_SIZE; kc++) begin : g_win_c
         assign w_window[2*(KERNEL_SIZE*KERNEL_SIZE-1-(kr*KERNEL_SIZE+kc)) +: 2] =
            w_pix[r_row + RC_W'(kr)][r_col + RC_W'(kc)];
      end
   end

   for (genvar f = 0; f < NUM_FEATURES; f++) begin : g_feat
      cnn_conv3x3 u_conv (
         .i_window (w_window),
         .i_kernel (r_kernel[f]),
         .o_sum    (w_conv_sum[f])
      );
   end

   // Pooled (i,j) covers conv rows/cols {2i,2i+1} x {2j,2j+1}.
   always_comb begin
      for (int f = 0; f < NUM_FEATURES; f++) begin
         w_pool_max[f] = max_s(
            max_s(r_conv[f][{r_prow,1'b0}][{r_pcol,1'b0}], r_conv[f][{r_prow,1'b0}][{r_pcol,1'b1}]),
            max_s(r_conv[f][{r_prow,1'b1}][{r_pcol,1'b0}], r_conv[f][{r_prow,1'b1}][{r_pcol,1'b1}]));
      end
   end

   // ---------------- FC multiply ----------------
   logic signed [OUTPUT_DATA_WIDTH-1:0] w_flat_ext, w_w_ext, w_prod;
   assign w_flat_ext = OUTPUT_DATA_WIDTH'(r_flat[r_fc_idx]);
   assign w_w_ext    = OUTPUT_DATA_WIDTH'(r_fc_w[r_fc_idx]);
   assign w_prod     = w_flat_ext * w_w_ext;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst_cnn) state <= IDLE;
      else         state <= w_next_state;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_next_state = state;
      case (state)
         IDLE:           if (!convolution_enable) w_next_state = CONVOLUTION;
         CONVOLUTION:    if (w_conv_last)         w_next_state = POOLING;
         POOLING:        if (w_pool_last)         w_next_state = FLATTENING;
         FLATTENING:                              w_next_state = FULLYCONNECTED;
         FULLYCONNECTED: if (w_fc_last)           w_next_state = OUTPUT;
         OUTPUT:                                  w_next_state = IDLE;
         default:                                 w_next_state = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_start   = 1'b0;
      w_conv_en = 1'b0;
      w_pool_en = 1'b0;
      w_flat_en = 1'b0;
      w_fc_en   = 1'b0;
      w_out_en  = 1'b0;
      case (state)
         IDLE:           w_start   = !convolution_enable;
         CONVOLUTION:    w_conv_en = 1'b1;
         POOLING:        w_pool_en = 1'b1;
         FLATTENING:     w_flat_en = 1'b1;
         FULLYCONNECTED: w_fc_en   = 1'b1;
         OUTPUT:         w_out_en  = 1'b1;
         default:        ;
      endcase
   end

   // ---------------- weight memories ----------------
   always_ff @(posedge clk) begin
      if (rst_feature_weights) begin
         for (int f = 0; f < NUM_FEATURES; f++) r_kernel[f] <= '0;
      end else if (state == IDLE && !feature_WrEn) begin
         // Slots outside 0..NUM_FEATURES-1 match no iteration and are dropped.
         for (int f = 0; f < NUM_FEATURES; f++) begin
            if (int'(feature_writeAddr) == f) r_kernel[f] <= feature_weights_input;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_fullyconnected_weights) begin
         for (int n = 0; n < FLATTENED_LENGTH; n++) r_fc_w[n] <= '0;
      end else if (state == IDLE && !fullyconnected_WrEn) begin
         for (int n = 0; n < FLATTENED_LENGTH; n++) begin
            r_fc_w[n] <= fullyconnected_weights_input[FCW_BITS-1-FULLYCONNECTED_DATA_WIDTH*n -: FULLYCONNECTED_DATA_WIDTH];
         end
      end
   end

   // ---------------- datapath ----------------
   // The conv/pool/flat arrays are always fully written before being read
   // in a run, so only the image, counters, accumulator and output are reset.
   always_ff @(posedge clk) begin
      if (rst_cnn) begin
         r_image    <= '0;
         r_row      <= '0;
         r_col      <= '0;
         r_prow     <= '0;
         r_pcol     <= '0;
         r_fc_idx   <= '0;
         r_acc      <= '0;
         cnn_output <= '0;
      end else begin
         if (w_start) begin
            r_image  <= image_input;
            r_row    <= '0;
            r_col    <= '0;
            r_prow   <= '0;
            r_pcol   <= '0;
            r_fc_idx <= '0;
            r_acc    <= '0;
         end

         if (w_conv_en) begin
            for (int f = 0; f < NUM_FEATURES; f++) r_conv[f][r_row][r_col] <= w_conv_sum[f];
            if (w_col_last) begin
               r_col <= '0;
               r_row <= w_conv_last ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end

         if (w_pool_en) begin
            for (int f = 0; f < NUM_FEATURES; f++) r_pool[f][r_prow][r_pcol] <= w_pool_max[f];
            if (w_pcol_last) begin
               r_pcol <= '0;
               r_prow <= w_pool_last ? '0 : r_prow + 1'b1;
            end else begin
               r_pcol <= r_pcol + 1'b1;
            end
         end

         if (w_flat_en) begin
            for (int f = 0; f < NUM_FEATURES; f++)
               for (int i = 0; i < POOLED_HEIGHT; i++)
                  for (int j = 0; j < POOLED_WIDTH; j++)
                     r_flat[f*POOLED_HEIGHT*POOLED_WIDTH + i*POOLED_WIDTH + j] <= r_pool[f][i][j];
            r_fc_idx <= '0;
         end

         if (w_fc_en) begin
            r_acc    <= r_acc + w_prod;
            r_fc_idx <= w_fc_last ? '0 : r_fc_idx + 1'b1;
         end

         if (w_out_en) cnn_output <= r_acc;
      end
   end

endmodule

// File: tb/tb_cnn_core.sv
// ---------------------------------------------------------------------------
// tb_cnn_core
// Directed and randomized runs of cnn_core, scored against a plain
// arithmetic model of the convolution / pooling / FC reduction.
// ---------------------------------------------------------------------------
module tb_cnn_core;

   localparam int IW = 12;
   localparam int IH = 12;
   localparam int NF = 2;
   localparam int NFLAT = 50;
   localparam int IMG_BITS = 2 * IW * IH;
   localparam int FCW_BITS = 8 * NFLAT;

   // ---------------- clock / reset / DUT ----------------
   logic                clk;
   logic                rst_cnn, rst_fw, rst_fcw;
   logic [IMG_BITS-1:0] image_input;
   logic [17:0]         feature_weights_input;
   logic [1:0]          feature_writeAddr;
   logic                feature_WrEn;
   logic [FCW_BITS-1:0] fullyconnected_weights_input;
   logic                fullyconnected_WrEn;
   logic                convolution_enable;
   logic [31:0]         cnn_output;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   cnn_core dut (
      .clk                          (clk),
      .rst_cnn                      (rst_cnn),
      .rst_feature_weights          (rst_fw),
      .rst_fullyconnected_weights   (rst_fcw),
      .image_input                  (image_input),
      .feature_weights_input        (feature_weights_input),
      .feature_writeAddr            (feature_writeAddr),
      .feature_WrEn                 (feature_WrEn),
      .fullyconnected_weights_input (fullyconnected_weights_input),
      .fullyconnected_WrEn          (fullyconnected_WrEn),
      .convolution_enable           (convolution_enable),
      .cnn_output                   (cnn_output)
   );

   // ---------------- reference data ----------------
   int img [IH][IW];
   int ker [NF][9];
   int fcw [NFLAT];
   int checks = 0;
   int fails  = 0;

   // Straight from the definitions: valid cross-correlation, 2x2 max,
   // flatten index f*25+i*5+j, dot product with the FC weights.
   function automatic int model();
      int conv [NF][10][10];
      int acc, m, s;
      for (int f = 0; f < NF; f++)
         for (int i = 0; i < 10; i++)
            for (int j = 0; j < 10; j++) begin
               s = 0;
               for (int kr = 0; kr < 3; kr++)
                  for (int kc = 0; kc < 3; kc++)
                     s += img[i+kr][j+kc] * ker[f][kr*3+kc];
               conv[f][i][j] = s;
            end
      acc = 0;
      for (int f = 0; f < NF; f++)
         for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) begin
               m = conv[f][2*i][2*j];
               if (conv[f][2*i][2*j+1]   > m) m = conv[f][2*i][2*j+1];
               if (conv[f][2*i+1][2*j]   > m) m = conv[f][2*i+1][2*j];
               if (conv[f][2*i+1][2*j+1] > m) m = conv[f][2*i+1][2*j+1];
               acc += m * fcw[f*25 + i*5 + j];
            end
      return acc;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
                tag, $signed(obs), obs, $signed(expv), expv);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic fill_image(input int v);
      for (int r = 0; r < IH; r++)
         for (int c = 0; c < IW; c++) img[r][c] = v;
   endtask

   task automatic set_kernels_x_ones();
      for (int k = 0; k < 9; k++) begin
         ker[0][k] = (k % 2 == 0) ? 1 : -1;
         ker[1][k] = 1;
      end
   endtask

   task automatic pack_image();
      for (int r = 0; r < IH; r++)
         for (int c = 0; c < IW; c++)
            image_input[IMG_BITS-1-2*(r*IW+c) -: 2] = 2'(img[r][c]);
   endtask

   task automatic write_kernel_raw(input logic [1:0] addr, input logic [17:0] bits);
      @(negedge clk);
      feature_writeAddr     = addr;
      feature_weights_input = bits;
      feature_WrEn          = 1'b0;
      @(negedge clk);
      feature_WrEn          = 1'b1;
   endtask

   task automatic load_kernel(input int slot);
      logic [17:0] bits;
      for (int k = 0; k < 9; k++) bits[17-2*k -: 2] = 2'(ker[slot][k]);
      write_kernel_raw(2'(slot), bits);
   endtask

   task automatic load_fc();
      @(negedge clk);
      for (int n = 0; n < NFLAT; n++) fullyconnected_weights_input[FCW_BITS-1-8*n -: 8] = 8'(fcw[n]);
      fullyconnected_WrEn = 1'b0;
      @(negedge clk);
      fullyconnected_WrEn = 1'b1;
   endtask

   // Start one run, count edges until IDLE is seen again, score latency and result.
   task automatic run_and_check(input string tag, input int expv, input bit scramble);
      int n;
      pack_image();
      @(negedge clk);
      convolution_enable = 1'b0;
      @(posedge clk); #1;
      convolution_enable = 1'b1;
      if (scramble) image_input = ~image_input;
      n = 0;
      while (dut.state != 0 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_latency"}, n, 177);
      check({tag, "_out"}, cnn_output, expv);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int n, expv;
      rst_cnn = 1'b1; rst_fw = 1'b1; rst_fcw = 1'b1;
      image_input = '0; feature_weights_input = '0; feature_writeAddr = '0;
      feature_WrEn = 1'b1; fullyconnected_weights_input = '0; fullyconnected_WrEn = 1'b1;
      convolution_enable = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", 32'(dut.state), 0);
      check("reset_out", cnn_output, 0);
      @(negedge clk);
      rst_cnn = 1'b0; rst_fw = 1'b0; rst_fcw = 1'b0;

      // X kernel + all-ones kernel, FC all 1, image all 1
      set_kernels_x_ones();
      load_kernel(0); load_kernel(1);
      for (int k = 0; k < NFLAT; k++) fcw[k] = 1;
      load_fc();
      fill_image(1);
      run_and_check("ones", 250, 1'b0);

      // FC +1 for the first feature, -1 for the second
      for (int k = 0; k < NFLAT; k++) fcw[k] = (k < 25) ? 1 : -1;
      load_fc();
      run_and_check("fc_split", -200, 1'b0);

      fill_image(0);
      run_and_check("zero_img", 0, 1'b0);

      for (int k = 0; k < NFLAT; k++) fcw[k] = 1;
      load_fc();
      fill_image(-1);
      run_and_check("neg_img", -250, 1'b0);

      // Single pixel; kernel slot 1 cleared by reset, not by a write
      @(negedge clk); rst_fw = 1'b1;
      @(negedge clk); rst_fw = 1'b0;
      load_kernel(0);
      fill_image(0);
      img[0][0] = 1;
      run_and_check("pixel_fc1", 1, 1'b0);
      @(negedge clk); rst_fcw = 1'b1;
      @(negedge clk); rst_fcw = 1'b0;
      run_and_check("pixel_fcrst", 0, 1'b0);
      for (int k = 0; k < NFLAT; k++) fcw[k] = 0;
      fcw[0] = 3;
      load_fc();
      run_and_check("pixel_w3", 3, 1'b0);

      // Abort 30 cycles into CONVOLUTION
      set_kernels_x_ones();
      load_kernel(1);
      for (int k = 0; k < NFLAT; k++) fcw[k] = 1;
      load_fc();
      fill_image(1);
      pack_image();
      @(negedge clk); convolution_enable = 1'b0;
      @(posedge clk); #1; convolution_enable = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("midrun_in_conv", 32'(dut.state), 1);
      rst_cnn = 1'b1;
      @(posedge clk); #1;
      check("midrun_rst_state", 32'(dut.state), 0);
      check("midrun_rst_out", cnn_output, 0);
      rst_cnn = 1'b0;
      run_and_check("restart", 250, 1'b0);

      // Enable held low for a whole run, weight writes attempted mid-run
      for (int r = 0; r < IH; r++)
         for (int c = 0; c < IW; c++) img[r][c] = int'($urandom_range(3, 0)) - 2;
      expv = model();
      pack_image();
      @(negedge clk); convolution_enable = 1'b0;
      @(posedge clk); #1;
      n = 0;
      while (dut.state != 0 && n < 400) begin
         @(posedge clk); #1;
         n++;
         if (n == 20) begin
            feature_writeAddr = 2'd0;
            feature_weights_input = 18'h15555;
            feature_WrEn = 1'b0;
            fullyconnected_weights_input = '0;
            fullyconnected_WrEn = 1'b0;
         end
         if (n == 21) begin
            feature_WrEn = 1'b1;
            fullyconnected_WrEn = 1'b1;
         end
      end
      check("hold_latency", n, 177);
      check("hold_out", cnn_output, expv);
      @(posedge clk); #1;
      check("hold_restart", 32'(dut.state), 1);
      convolution_enable = 1'b1;
      rst_cnn = 1'b1;
      @(posedge clk); #1;
      rst_cnn = 1'b0;
      check("hold_abort_state", 32'(dut.state), 0);
      run_and_check("weights_kept", expv, 1'b0);

      // Random images, kernels and FC weights; odd runs corrupt the image after start
      for (int t = 0; t < 6; t++) begin
         for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) img[r][c] = int'($urandom_range(3, 0)) - 2;
         for (int f = 0; f < NF; f++)
            for (int k = 0; k < 9; k++) ker[f][k] = int'($urandom_range(3, 0)) - 2;
         for (int k = 0; k < NFLAT; k++) fcw[k] = int'($urandom_range(255, 0)) - 128;
         load_kernel(0); load_kernel(1);
         write_kernel_raw(2'd2, 18'($urandom));
         write_kernel_raw(2'd3, 18'($urandom));
         load_fc();
         run_and_check($sformatf("rand%0d", t), model(), t[0]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
